j11busctl: RTL and testbench
============================

J11BUSCTL -- requirements
Module: j11busctl

Interface
REQ-001 Parameter NIRQ, default 8, number of interrupt channels, range 1..16.
REQ-002 Parameter VECTORS, default channel i = 16'o60+4*i, packed NIRQ*16 bits, vector returned for each channel.
REQ-003 Parameter LEVELS, default all 0, packed NIRQ*2 bits, J11 IRQ line (0..3) for each channel.
REQ-004 Parameter TIMEOUT, default 255, memory wait limit in clk cycles, range 1..65535.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 busreq, buswr, busgp, busirq  in  1 each  CPU cycle request, write, general-purpose (GP) space, interrupt acknowledge.
REQ-008 busaddr  in  22; buswdata  in  16; buswstrb  in  2  CPU address, write data, byte strobes.
REQ-009 busack, buserr  out  1 each; busrdata  out  16  cycle completion, error, read data.
REQ-010 busrst  out  1  bus reset request to peripherals.
REQ-011 memreq  out  1; memwr  out  1; memaddr  out  22; memwdata  out  16; memwstrb  out  2  memory request (registered copy of the CPU cycle).
REQ-012 memack, memerr  in  1 each; memrdata  in  16  memory completion.
REQ-013 irq  in  NIRQ  per-channel interrupt pulses, rising-edge significant.
REQ-014 j11irq  out  4  J11 interrupt request lines.
REQ-015 odt  out  1  ODT halt mode flag.

Function
REQ-016 States SHALL be IDLE and MEMWAIT; busreq is sampled only in IDLE and ignored in MEMWAIT.
REQ-017 IDLE, busreq&busgp: busack=1, buserr=0 next cycle; writes decode busaddr[7:0]: 8'o14 sets busrst, 8'o214 clears busrst, 8'o34 sets odt, 8'o234 clears odt; any other GP write is acknowledged with no effect.
REQ-018 IDLE, GP read at 8'o0 SHALL return 16'o5; other GP reads return 0.
REQ-019 IDLE, busreq&busirq: level L is the lowest set bit of busaddr[3:0]; the lowest-index pending channel with LEVELS=L has its vector returned and its pending bit cleared; busack next cycle.
REQ-020 If no channel qualifies, busrdata=0 with busack=1, buserr=0.
REQ-021 IDLE, other busreq: latch address, data, strobes, write into mem* outputs, pulse memreq for one cycle, enter MEMWAIT, load timeout counter with TIMEOUT.
REQ-022 MEMWAIT, memack: busack=1, busrdata=memrdata, buserr=memerr next cycle, return to IDLE.
REQ-023 MEMWAIT, no memack: decrement counter; on reaching 0, busack=1, buserr=1, busrdata=0, return to IDLE.
REQ-024 memack arriving in IDLE SHALL be ignored.
REQ-025 busack and buserr SHALL be single-cycle pulses.
REQ-026 Pending bit i SHALL set on an irq[i] 0->1 transition.
REQ-027 A set and an acknowledge-clear of the same bit in one cycle SHALL leave the bit set.
REQ-028 j11irq[L] SHALL be registered, high when any pending channel has LEVELS=L; one-cycle latency from pending.

Reset
REQ-029 rst SHALL force IDLE; busack=0, buserr=0, busrdata=0, memreq=0, mem* data=0, pending=0, j11irq=0, odt=0, busrst=1, irq edge history=0.
REQ-030 rst during MEMWAIT SHALL abandon the cycle; no busack is issued for it.

Structure
REQ-031 GP register offsets, powerup word and state encoding SHALL live in shared package j11_pkg.
REQ-032 Pending, edge detect, priority select and j11irq SHALL form sub-module j11intc (parameters NIRQ, VECTORS, LEVELS); bus FSM and timeout stay in j11busctl.

Verification
REQ-033 GP write 8'o214, then GP read 8'o0 -> busrst 1->0; read busrdata=16'o5, busack 1 cycle.
REQ-034 NIRQ=4, LEVELS all 0, pulse irq[2] then irq[1]; IACK busaddr[3:0]=4'b0001 twice -> 16'o64 then 16'o70; j11irq[0] drops after the second acknowledge.
REQ-035 IACK with nothing pending -> busrdata=0, busack=1, buserr=0.
REQ-036 Memory read, memack after 3 cycles with memrdata=16'o123456 -> busrdata=16'o123456, buserr=0; a second busreq during the wait produces no memreq.
REQ-037 TIMEOUT=4, no memack -> busack+buserr exactly 5 cycles after memreq; later memack ignored.
REQ-038 irq[0] rising edge in the same cycle as its acknowledge -> pending stays set, j11irq[0] remains 1.

Source files
------------

// File: rtl/j11_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : j11_pkg
//  Description : Shared constants for the J11 bus controller: GP register
//                offsets, the powerup word returned by the ID read, the bus
//                FSM state encoding and small helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package j11_pkg;

    // GP space register offsets (busaddr[7:0])
    localparam logic [7:0]  c_gp_id         = 8'o0;
    localparam logic [7:0]  c_gp_busrst_set = 8'o14;
    localparam logic [7:0]  c_gp_busrst_clr = 8'o214;
    localparam logic [7:0]  c_gp_odt_set    = 8'o34;
    localparam logic [7:0]  c_gp_odt_clr    = 8'o234;

    // Word returned by a GP read of the ID offset
    localparam logic [15:0] c_powerup_word  = 16'o5;

    // Bus FSM state encoding
    localparam logic [0:0]  c_st_idle       = 1'b0;
    localparam logic [0:0]  c_st_memwait    = 1'b1;

    // Default vector table for up to 16 channels: channel i -> 060 + 4*i
    function automatic logic [255:0] f_default_vectors();
        logic [255:0] vec;
        for (int i = 0; i < 16; i++) begin
            vec[16*i +: 16] = 16'(16'o60 + 4 * i);
        end
        return vec;
    endfunction

    localparam logic [255:0] c_default_vectors = f_default_vectors();

    // IACK level select: the lowest set bit of sel names the level.
    // Result is {valid, level}; valid is 0 when sel is all zero.
    function automatic logic [2:0] f_iack_level(input logic [3:0] sel);
        logic [2:0] lvl;
        lvl = 3'b000;
        for (int b = 3; b >= 0; b--) begin
            if (sel[b]) begin
                lvl = {1'b1, 2'(b)};
            end
        end
        return lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/j11intc.sv
`default_nettype none
// ============================================================================
//  Module      : j11intc
//  Description : Interrupt controller for the J11 bus controller. Detects
//                rising edges on irq, keeps one pending bit per channel,
//                selects the lowest-index pending channel of the requested
//                level on acknowledge and drives the registered j11irq lines.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                irq           - per-channel interrupt inputs (edge significant)
//                ack           - acknowledge strobe (clears the selected bit)
//                acksel        - level select, lowest set bit is the level
//                ackvec        - vector of the selected channel, 0 if none
//                j11irq        - per-level request lines (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module j11intc
    import j11_pkg::*;
#(
    parameter int                 NIRQ    = 8,
    parameter logic [NIRQ*16-1:0] VECTORS = c_default_vectors[NIRQ*16-1:0],
    parameter logic [NIRQ*2-1:0]  LEVELS  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic            ack,
    input  logic [3:0]      acksel,
    output logic [15:0]     ackvec,
    output logic [3:0]      j11irq
);

    logic [NIRQ-1:0] r_irq_d;
    logic [NIRQ-1:0] r_pend;
    logic [NIRQ-1:0] w_rise;
    logic [NIRQ-1:0] w_clr;
    logic [2:0]      w_lvl;
    logic            w_hit;
    logic [3:0]      w_lvl_any;

    assign w_rise = irq & ~r_irq_d;

    // Priority select: the first match scanning upward wins.
    always_comb begin
        w_lvl  = f_iack_level(acksel);
        w_hit  = 1'b0;
        w_clr  = '0;
        ackvec = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (!w_hit && w_lvl[2] && r_pend[i] &&
                (LEVELS[2*i +: 2] == w_lvl[1:0])) begin
                w_hit    = 1'b1;
                w_clr[i] = 1'b1;
                ackvec   = VECTORS[16*i +: 16];
            end
        end
    end

    always_comb begin
        w_lvl_any = '0;
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < NIRQ; i++) begin
                if (r_pend[i] && (LEVELS[2*i +: 2] == 2'(l))) begin
                    w_lvl_any[l] = 1'b1;
                end
            end
        end
    end

    // Set wins over clear: a fresh edge arriving with its own acknowledge
    // keeps the channel pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_d <= '0;
            r_pend  <= '0;
            j11irq  <= '0;
        end else begin
            r_irq_d <= irq;
            r_pend  <= (r_pend & ~({NIRQ{ack}} & w_clr)) | w_rise;
            j11irq  <= w_lvl_any;
        end
    end

endmodule
`default_nettype wire

// File: rtl/j11busctl.sv
`default_nettype none
// ============================================================================
//  Module      : j11busctl
//  Description : J11 CPU bus controller. Serves GP-space register cycles and
//                interrupt acknowledge cycles locally, forwards all other
//                cycles to memory with a timeout, and hosts the interrupt
//                controller.
//  Ports       : clk, rst                       - clock, sync active-high reset
//                busreq/buswr/busgp/busirq      - CPU cycle request qualifiers
//                busaddr/buswdata/buswstrb      - CPU address, data, strobes
//                busack/buserr/busrdata         - cycle completion (1-cycle pulse)
//                busrst                         - peripheral reset request
//                memreq/memwr/memaddr/
//                memwdata/memwstrb              - registered memory request
//                memack/memerr/memrdata         - memory completion
//                irq                            - interrupt inputs
//                j11irq                         - J11 interrupt request lines
//                odt                            - ODT halt mode flag
//  Revision    : 1.0 - initial release
// ============================================================================
module j11busctl
    import j11_pkg::*;
#(
    parameter int                 NIRQ    = 8,
    parameter logic [NIRQ*16-1:0] VECTORS = c_default_vectors[NIRQ*16-1:0],
    parameter logic [NIRQ*2-1:0]  LEVELS  = '0,
    parameter int                 TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            busreq,
    input  logic            buswr,
    input  logic            busgp,
    input  logic            busirq,
    input  logic [21:0]     busaddr,
    input  logic [15:0]     buswdata,
    input  logic [1:0]      buswstrb,
    output logic            busack,
    output logic            buserr,
    output logic [15:0]     busrdata,
    output logic            busrst,
    output logic            memreq,
    output logic            memwr,
    output logic [21:0]     memaddr,
    output logic [15:0]     memwdata,
    output logic [1:0]      memwstrb,
    input  logic            memack,
    input  logic            memerr,
    input  logic [15:0]     memrdata,
    input  logic [NIRQ-1:0] irq,
    output logic [3:0]      j11irq,
    output logic            odt
);

    localparam logic [15:0] c_timeout_ld = 16'(TIMEOUT);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [15:0] r_cnt;

    logic        w_idle;
    logic        w_start_gp;
    logic        w_start_iack;
    logic        w_start_mem;
    logic        w_mem_done;
    logic        w_mem_to;

    logic        w_ack_nxt;
    logic        w_err_nxt;
    logic [15:0] w_rdata_nxt;
    logic [15:0] w_ackvec;

    // Request decode: busreq is only looked at in IDLE; GP takes precedence
    // over IACK, and anything else goes to memory.
    assign w_idle       = (r_state == c_st_idle);
    assign w_start_gp   = w_idle & busreq & busgp;
    assign w_start_iack = w_idle & busreq & ~busgp & busirq;
    assign w_start_mem  = w_idle & busreq & ~busgp & ~busirq;
    assign w_mem_done   = (r_state == c_st_memwait) & memack;
    assign w_mem_to     = (r_state == c_st_memwait) & ~memack & (r_cnt == 16'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_start_mem) begin
                    w_state_nxt = c_st_memwait;
                end
            end
            c_st_memwait: begin
                if (w_mem_done || w_mem_to) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Output decode: values the bus outputs take after the next edge
    always_comb begin
        w_ack_nxt   = w_start_gp | w_start_iack | w_mem_done | w_mem_to;
        w_err_nxt   = (w_mem_done & memerr) | w_mem_to;
        w_rdata_nxt = 16'd0;
        if (w_start_gp) begin
            if (!buswr && (busaddr[7:0] == c_gp_id)) begin
                w_rdata_nxt = c_powerup_word;
            end
        end else if (w_start_iack) begin
            w_rdata_nxt = w_ackvec;
        end else if (w_mem_done) begin
            w_rdata_nxt = memrdata;
        end
    end

    // Registered outputs, GP registers and timeout counter.
    // The counter runs down to zero and the timeout fires on the following
    // edge, so the error lands TIMEOUT+1 cycles after memreq.
    always_ff @(posedge clk) begin
        if (rst) begin
            busack   <= 1'b0;
            buserr   <= 1'b0;
            busrdata <= '0;
            busrst   <= 1'b1;
            odt      <= 1'b0;
            memreq   <= 1'b0;
            memwr    <= 1'b0;
            memaddr  <= '0;
            memwdata <= '0;
            memwstrb <= '0;
            r_cnt    <= '0;
        end else begin
            busack   <= w_ack_nxt;
            buserr   <= w_err_nxt;
            busrdata <= w_rdata_nxt;
            memreq   <= w_start_mem;
            if (w_start_mem) begin
                memwr    <= buswr;
                memaddr  <= busaddr;
                memwdata <= buswdata;
                memwstrb <= buswstrb;
                r_cnt    <= c_timeout_ld;
            end else if ((r_state == c_st_memwait) && (r_cnt != 16'd0)) begin
                r_cnt <= r_cnt - 16'd1;
            end
            if (w_start_gp && buswr) begin
                case (busaddr[7:0])
                    c_gp_busrst_set: busrst <= 1'b1;
                    c_gp_busrst_clr: busrst <= 1'b0;
                    c_gp_odt_set:    odt    <= 1'b1;
                    c_gp_odt_clr:    odt    <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    j11intc #(
        .NIRQ    (NIRQ),
        .VECTORS (VECTORS),
        .LEVELS  (LEVELS)
    ) u_intc (
        .clk    (clk),
        .rst    (rst),
        .irq    (irq),
        .ack    (w_start_iack),
        .acksel (busaddr[3:0]),
        .ackvec (w_ackvec),
        .j11irq (j11irq)
    );

endmodule
`default_nettype wire

// File: tb/tb_j11busctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_j11busctl
//  Description : Self-checking bench for j11busctl. A cycle-level behavioural
//                model tracks pending interrupts as a bit set, the memory
//                cycle as a deadline in edge numbers and the GP flags as
//                plain bits; a compare process checks the DUT every cycle.
//                Directed sequences pin the model with literal values, then
//                randomized traffic runs against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_j11busctl;

    localparam int         NIRQ = 4;
    localparam int         TMO  = 4;
    // channels 0..2 on level 0, channel 3 on level 2
    localparam logic [7:0] LV   = 8'b10_00_00_00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busreq = 1'b0, buswr = 1'b0, busgp = 1'b0, busirq = 1'b0;
    logic [21:0] busaddr = '0;
    logic [15:0] buswdata = '0;
    logic [1:0]  buswstrb = '0;
    logic        busack, buserr, busrst, memreq, memwr, odt;
    logic [15:0] busrdata, memwdata;
    logic [21:0] memaddr;
    logic [1:0]  memwstrb;
    logic        memack = 1'b0, memerr = 1'b0;
    logic [15:0] memrdata = '0;
    logic [3:0]  irq = '0;
    logic [3:0]  j11irq;

    always #5 clk = ~clk;

    j11busctl #(
        .NIRQ    (NIRQ),
        .LEVELS  (LV),
        .TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .busreq   (busreq),
        .buswr    (buswr),
        .busgp    (busgp),
        .busirq   (busirq),
        .busaddr  (busaddr),
        .buswdata (buswdata),
        .buswstrb (buswstrb),
        .busack   (busack),
        .buserr   (buserr),
        .busrdata (busrdata),
        .busrst   (busrst),
        .memreq   (memreq),
        .memwr    (memwr),
        .memaddr  (memaddr),
        .memwdata (memwdata),
        .memwstrb (memwstrb),
        .memack   (memack),
        .memerr   (memerr),
        .memrdata (memrdata),
        .irq      (irq),
        .j11irq   (j11irq),
        .odt      (odt)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit rnd_irq = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         lev [4] = '{0, 0, 0, 2};
    bit         m_on = 1'b0;
    bit         m_wait;
    int         m_edge, m_deadline;
    logic [3:0] m_pend, m_prev;
    logic       m_busrst, m_odt;
    logic       e_ack, e_err, e_memreq, e_memwr;
    logic [15:0] e_rdata, e_memwdata;
    logic [21:0] e_memaddr;
    logic [1:0]  e_memwstrb;
    logic [3:0]  e_j11irq;

    always @(posedge clk) begin
        logic [3:0] clr;
        int         lvl;
        clr = '0;
        if (rst) begin
            m_on = 1'b1; m_wait = 1'b0; m_edge = 0; m_deadline = 0;
            m_pend = '0; m_prev = '0; m_busrst = 1'b1; m_odt = 1'b0;
            e_ack = 1'b0; e_err = 1'b0; e_rdata = '0; e_memreq = 1'b0;
            e_memwr = 1'b0; e_memaddr = '0; e_memwdata = '0; e_memwstrb = '0;
            e_j11irq = '0;
        end else if (m_on) begin
            // request lines reflect what was pending before this edge
            e_j11irq = '0;
            for (int c = 0; c < NIRQ; c++)
                if (m_pend[c]) e_j11irq[lev[c]] = 1'b1;
            e_ack = 1'b0; e_err = 1'b0; e_rdata = '0; e_memreq = 1'b0;
            if (!m_wait) begin
                if (busreq && busgp) begin
                    e_ack = 1'b1;
                    if (buswr) begin
                        if (busaddr[7:0] == 8'o14)  m_busrst = 1'b1;
                        if (busaddr[7:0] == 8'o214) m_busrst = 1'b0;
                        if (busaddr[7:0] == 8'o34)  m_odt = 1'b1;
                        if (busaddr[7:0] == 8'o234) m_odt = 1'b0;
                    end else if (busaddr[7:0] == 8'o0) begin
                        e_rdata = 16'o5;
                    end
                end else if (busreq && busirq) begin
                    e_ack = 1'b1;
                    lvl = -1;
                    for (int b = 3; b >= 0; b--) if (busaddr[b]) lvl = b;
                    for (int c = 0; c < NIRQ; c++) begin
                        if (lvl >= 0 && clr == 0 && m_pend[c] && lev[c] == lvl) begin
                            clr[c] = 1'b1;
                            e_rdata = 16'(16'o60 + 4 * c);
                        end
                    end
                end else if (busreq) begin
                    e_memreq = 1'b1; e_memwr = buswr; e_memaddr = busaddr;
                    e_memwdata = buswdata; e_memwstrb = buswstrb;
                    m_wait = 1'b1; m_deadline = m_edge + TMO + 1;
                end
            end else if (memack) begin
                e_ack = 1'b1; e_err = memerr; e_rdata = memrdata; m_wait = 1'b0;
            end else if (m_edge == m_deadline) begin
                e_ack = 1'b1; e_err = 1'b1; m_wait = 1'b0;
            end
            m_pend = (m_pend & ~clr) | (irq & ~m_prev);
            m_prev = irq;
            m_edge++;
        end
        #1;
        if (m_on) begin
            chk("busack", busack, e_ack);
            chk("buserr", buserr, e_err);
            if (e_ack) chk("busrdata", busrdata, e_rdata);
            chk("busrst", busrst, m_busrst);
            chk("odt", odt, m_odt);
            chk("memreq", memreq, e_memreq);
            chk("j11irq", j11irq, e_j11irq);
            if (e_memreq) begin
                chk("memaddr", memaddr, e_memaddr);
                chk("memwr", memwr, e_memwr);
                chk("memwdata", memwdata, e_memwdata);
                chk("memwstrb", memwstrb, e_memwstrb);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        if (rnd_irq && $urandom_range(0, 3) == 0)
            irq = irq ^ 4'(1 << $urandom_range(0, 3));
    endtask

    // One CPU cycle. mdel = cycles until memack (-1: never). lat is the
    // number of cycles from the request edge to busack visibility.
    task automatic bus_op(input bit gp, input bit ia, input bit wr,
                          input logic [21:0] addr, input logic [15:0] wd,
                          input int mdel, input logic [15:0] mrd, input bit merr,
                          input logic [3:0] itog, input bit extra,
                          output logic [15:0] rd, output logic er,
                          output int lat, output int nreq);
        int k;
        bit got;
        @(negedge clk);
        busreq = 1'b1; busgp = gp; busirq = ia; buswr = wr;
        busaddr = addr; buswdata = wd; buswstrb = 2'($urandom);
        irq = irq ^ itog;
        tick();
        busreq = 1'b0; busgp = 1'b0; busirq = 1'b0; buswr = 1'b0;
        k = 0; got = 1'b0; nreq = 0; lat = -1; rd = '0; er = 1'b0;
        while (!got && k < 40) begin
            if (memreq) nreq++;
            if (busack) begin
                got = 1'b1; rd = busrdata; er = buserr; lat = k;
            end else begin
                memack = (mdel >= 0 && k == mdel);
                memrdata = mrd; memerr = merr;
                if (extra && k == 1) busreq = 1'b1;
                if (extra && k == 2) busreq = 1'b0;
                tick();
                k++;
            end
        end
        memack = 1'b0; busreq = 1'b0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL bus_op_timeout: no busack within 40 cycles for addr %0h", addr);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat, nr;
        logic [7:0]  gpa [7] = '{8'o0, 8'o2, 8'o14, 8'o214, 8'o34, 8'o234, 8'o77};
        bit          seen;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busack", busack, 0);
        chk("rst_buserr", buserr, 0);
        chk("rst_busrdata", busrdata, 0);
        chk("rst_busrst", busrst, 1);
        chk("rst_odt", odt, 0);
        chk("rst_memreq", memreq, 0);
        chk("rst_memaddr", memaddr, 0);
        chk("rst_j11irq", j11irq, 0);
        rst = 1'b0;

        // GP registers
        bus_op(1, 0, 1, 22'o214, 0, -1, 0, 0, 0, 0, rd, er, lat, nr);
        chk("gp214_lat", lat, 0);
        chk("gp214_busrst", busrst, 0);
        tick();
        chk("gp_ack_pulse", busack, 0);
        bus_op(1, 0, 0, 22'o0, 0, -1, 0, 0, 0, 0, rd, er, lat, nr);
        chk("gp_id_rdata", rd, 16'o5);
        chk("gp_id_err", er, 0);
        tick();
        chk("gp_id_pulse", busack, 0);
        bus_op(1, 0, 1, 22'o34, 0, -1, 0, 0, 0, 0, rd, er, lat, nr);
        chk("gp_odt_set", odt, 1);
        bus_op(1, 0, 0, 22'o2, 0, -1, 0, 0, 0, 0, rd, er, lat, nr);
        chk("gp_rd_other", rd, 0);
        bus_op(1, 0, 1, 22'o14, 0, -1, 0, 0, 0, 0, rd, er, lat, nr);
        chk("gp_busrst_set", busrst, 1);
        bus_op(1, 0, 1, 22'o234, 0, -1, 0, 0, 0, 0, rd, er, lat, nr);
        chk("gp_odt_clr", odt, 0);

        // interrupts: irq[2] then irq[1], both level 0
        irq = 4'b0100; tick(); irq = '0; tick();
        irq = 4'b0010; tick(); irq = '0; tick(); tick();
        chk("j11irq_l0", j11irq, 4'b0001);
        bus_op(0, 1, 0, 22'h1, 0, -1, 0, 0, 0, 0, rd, er, lat, nr);
        chk("iack1_vec", rd, 16'o64);
        bus_op(0, 1, 0, 22'h1, 0, -1, 0, 0, 0, 0, rd, er, lat, nr);
        chk("iack2_vec", rd, 16'o70);
        tick();
        chk("j11irq_drop", j11irq, 0);
        bus_op(0, 1, 0, 22'h1, 0, -1, 0, 0, 0, 0, rd, er, lat, nr);
        chk("iack_none_vec", rd, 0);
        chk("iack_none_err", er, 0);

        // level select: channel 3 sits on level 2
        irq = 4'b1000; tick(); irq = '0; tick(); tick();
        chk("j11irq_l2", j11irq, 4'b0100);
        bus_op(0, 1, 0, 22'h1, 0, -1, 0, 0, 0, 0, rd, er, lat, nr);
        chk("iack_l0_empty", rd, 0);
        bus_op(0, 1, 0, 22'hC, 0, -1, 0, 0, 0, 0, rd, er, lat, nr);
        chk("iack_l2_vec", rd, 16'o74);
        tick();
        chk("j11irq_l2_drop", j11irq, 0);

        // set and acknowledge of channel 0 in the same cycle
        irq = 4'b0001; tick(); irq = '0; tick(); tick();
        bus_op(0, 1, 0, 22'h1, 0, -1, 0, 0, 4'b0001, 0, rd, er, lat, nr);
        chk("iack_setclr_vec", rd, 16'o60);
        irq = '0; tick(); tick();
        chk("setclr_j11irq", j11irq, 4'b0001);
        bus_op(0, 1, 0, 22'h1, 0, -1, 0, 0, 0, 0, rd, er, lat, nr);
        chk("iack_again_vec", rd, 16'o60);
        tick(); tick();
        chk("setclr_drop", j11irq, 0);

        // memory read, memack after 3 cycles, extra busreq during the wait
        bus_op(0, 0, 0, 22'o1234567, 0, 3, 16'o123456, 0, 0, 1, rd, er, lat, nr);
        chk("mem_rdata", rd, 16'o123456);
        chk("mem_err", er, 0);
        chk("mem_lat", lat, 4);
        chk("mem_nreq", nr, 1);
        chk("mem_addr", memaddr, 22'o1234567);

        // memory write completing with an error
        bus_op(0, 0, 1, 22'h3ABCD, 16'hBEEF, 0, 16'h1111, 1, 0, 0, rd, er, lat, nr);
        chk("memw_err", er, 1);
        chk("memw_lat", lat, 1);
        chk("memw_wdata", memwdata, 16'hBEEF);
        chk("memw_wr", memwr, 1);

        // timeout, then a late memack that must be ignored
        bus_op(0, 0, 0, 22'h100, 0, -1, 16'h5555, 0, 0, 0, rd, er, lat, nr);
        chk("to_lat", lat, TMO + 1);
        chk("to_err", er, 1);
        chk("to_rdata", rd, 0);
        memack = 1'b1; tick(); memack = 1'b0;
        chk("late_memack", busack, 0);
        tick();
        chk("late_memack2", busack, 0);

        // reset in the middle of a memory wait
        @(negedge clk);
        busreq = 1'b1; busaddr = 22'h200; tick(); busreq = 1'b0;
        tick(); rst = 1'b1; tick(); rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (busack) seen = 1'b1;
        end
        chk("rst_abandon", seen, 0);
        chk("rst_busrst_again", busrst, 1);

        // randomized traffic
        rnd_irq = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int op, md;
            op = $urandom_range(0, 9);
            if (op <= 2) begin
                bus_op(1, 0, 1'($urandom), {14'($urandom), gpa[$urandom_range(0, 6)]},
                       16'($urandom), -1, 0, 0, 0, 0, rd, er, lat, nr);
            end else if (op <= 5) begin
                bus_op(0, 1, 0, 22'($urandom), 0, -1, 0, 0,
                       4'($urandom_range(0, 15)) & 4'($urandom), 0, rd, er, lat, nr);
            end else begin
                md = $urandom_range(0, 7);
                if (md == 7) md = -1;
                bus_op(0, 0, 1'($urandom), 22'($urandom), 16'($urandom), md,
                       16'($urandom), 1'($urandom), 0, 1'($urandom), rd, er, lat, nr);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd_irq = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
